// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator. Holds the fetch PC, advances it each
// cycle, applies taken-branch redirects (holding one across a fetch stall), and
// raises Flush1 in the cycle a redirected PC is presented. Every output comes
// straight from a register, so no input reaches an output in the same cycle.
//
// Handshake note: there is no valid/ready pairing on this block. br_take is a
// single-cycle qualifier for br_target, and start is a level sampled on each
// edge while in IDLE or HALTED.
module pc_gen #(
    parameter int unsigned    AW           = 9,
    parameter logic [AW-1:0]  RESET_VECTOR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          Stall1,
    input  logic          br_take,
    input  logic [AW-1:0] br_target,
    input  logic          halt_req,
    output logic [AW-1:0] PC,
    output logic          pc_valid,
    output logic          Flush1,
    output logic          redirect_pending,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] held_q, held_d;
    logic          pending_q, pending_d;
    logic          flush_q, flush_d;

    // State register: reset forces the whole block back to its idle values at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_VECTOR;
            held_q    <= '0;
            pending_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            held_q    <= held_d;
            pending_q <= pending_d;
            flush_q   <= flush_d;
        end
    end

    // Next-state logic: in RUN the redirect rules are checked in priority order;
    // a redirect (taken, deferred or being held) always beats a halt request.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        held_d    = held_q;
        pending_d = pending_q;
        flush_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (pending_q && !Stall1) begin
                    // Stall released: present the deferred target.
                    pc_d      = held_q;
                    pending_d = 1'b0;
                    flush_d   = 1'b1;
                end else if (br_take && !Stall1 && !pending_q) begin
                    pc_d    = br_target;
                    flush_d = 1'b1;
                end else if (br_take && Stall1 && !pending_q) begin
                    // Capture the target; it is applied once the stall drops.
                    held_d    = br_target;
                    pending_d = 1'b1;
                end else if (halt_req && !pending_q) begin
                    state_d = ST_HALTED;
                end else if (Stall1) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end

            ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = pc_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign PC               = pc_q;
    assign pc_valid         = (state_q == ST_RUN);
    assign Flush1           = flush_q;
    assign redirect_pending = pending_q;
    assign state            = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: each task drives one scenario and checks the
// registered outputs 1 ns after the rising edge.
module tb_pc_gen;

    localparam int AW = 9;

    logic          clk;
    logic          reset;
    logic          start;
    logic          Stall1;
    logic          br_take;
    logic [AW-1:0] br_target;
    logic          halt_req;
    logic [AW-1:0] PC;
    logic          pc_valid;
    logic          Flush1;
    logic          redirect_pending;
    logic [1:0]    state;

    int checks;
    int failures;

    pc_gen #(.AW(AW), .RESET_VECTOR('0)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .Stall1           (Stall1),
        .br_take          (br_take),
        .br_target        (br_target),
        .halt_req         (halt_req),
        .PC               (PC),
        .pc_valid         (pc_valid),
        .Flush1           (Flush1),
        .redirect_pending (redirect_pending),
        .state            (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        Stall1    = 1'b0;
        br_take   = 1'b0;
        br_target = '0;
        halt_req  = 1'b0;
    endtask

    // Drive a branch to target and check it lands (used to position the PC).
    task automatic go_to(input logic [AW-1:0] tgt);
        br_take   = 1'b1;
        br_target = tgt;
        step();
        br_take   = 1'b0;
        checks++;
        if (PC !== tgt) begin
            failures++;
            $display("FAIL go_to_pc got=%h exp=%h", PC, tgt);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (PC !== 9'h000 || state !== 2'b00 || pc_valid !== 1'b0 || Flush1 !== 1'b0 || redirect_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_values pc=%h st=%b v=%b f=%b p=%b exp pc=000 st=00 v=0 f=0 p=0",
                     PC, state, pc_valid, Flush1, redirect_pending);
        end
        reset = 1'b0;
        // IDLE ignores everything except start.
        br_take = 1'b1; br_target = 9'h0AB; Stall1 = 1'b1; halt_req = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (PC !== 9'h000 || state !== 2'b00 || Flush1 !== 1'b0 || redirect_pending !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores pc=%h st=%b f=%b p=%b exp pc=000 st=00 f=0 p=0",
                     PC, state, Flush1, redirect_pending);
        end
    endtask

    task automatic test_start_count();
        logic [AW-1:0] exp_pc [5];
        exp_pc[0] = 9'h000; exp_pc[1] = 9'h001; exp_pc[2] = 9'h002;
        exp_pc[3] = 9'h003; exp_pc[4] = 9'h004;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            start = 1'b0;
            checks++;
            if (PC !== exp_pc[i] || pc_valid !== 1'b1 || state !== 2'b01 || Flush1 !== 1'b0) begin
                failures++;
                $display("FAIL start_count[%0d] pc=%h v=%b st=%b f=%b exp pc=%h v=1 st=01 f=0",
                         i, PC, pc_valid, state, Flush1, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch();
        go_to(9'h010);
        checks++;
        if (Flush1 !== 1'b1) begin
            failures++;
            $display("FAIL branch_flush_a got=%b exp=1", Flush1);
        end
        // Second redirect on the very next edge: Flush1 stays high.
        br_take = 1'b1; br_target = 9'h1A0;
        step();
        br_take = 1'b0;
        checks++;
        if (PC !== 9'h1A0 || Flush1 !== 1'b1) begin
            failures++;
            $display("FAIL branch_b2b pc=%h f=%b exp pc=1a0 f=1", PC, Flush1);
        end
        step();
        checks++;
        if (PC !== 9'h1A1 || Flush1 !== 1'b0) begin
            failures++;
            $display("FAIL branch_after pc=%h f=%b exp pc=1a1 f=0", PC, Flush1);
        end
    endtask

    task automatic test_stall_redirect();
        Stall1 = 1'b1; br_take = 1'b1; br_target = 9'h055;
        step();
        checks++;
        if (PC !== 9'h1A1 || redirect_pending !== 1'b1 || Flush1 !== 1'b0) begin
            failures++;
            $display("FAIL stall_cap pc=%h p=%b f=%b exp pc=1a1 p=1 f=0", PC, redirect_pending, Flush1);
        end
        br_target = 9'h077;
        step();
        br_take = 1'b0;
        checks++;
        if (PC !== 9'h1A1 || redirect_pending !== 1'b1) begin
            failures++;
            $display("FAIL stall_second pc=%h p=%b exp pc=1a1 p=1", PC, redirect_pending);
        end
        // Halt while a redirect is pending is dropped.
        halt_req = 1'b1;
        step();
        checks++;
        if (PC !== 9'h1A1 || redirect_pending !== 1'b1 || state !== 2'b01) begin
            failures++;
            $display("FAIL stall_hold pc=%h p=%b st=%b exp pc=1a1 p=1 st=01", PC, redirect_pending, state);
        end
        Stall1 = 1'b0;
        step();
        halt_req = 1'b0;
        checks++;
        if (PC !== 9'h055 || Flush1 !== 1'b1 || redirect_pending !== 1'b0 || state !== 2'b01) begin
            failures++;
            $display("FAIL stall_release pc=%h f=%b p=%b st=%b exp pc=055 f=1 p=0 st=01",
                     PC, Flush1, redirect_pending, state);
        end
        step();
        checks++;
        if (PC !== 9'h056 || Flush1 !== 1'b0) begin
            failures++;
            $display("FAIL stall_after pc=%h f=%b exp pc=056 f=0", PC, Flush1);
        end
        // Plain stall holds the PC.
        Stall1 = 1'b1;
        step();
        step();
        Stall1 = 1'b0;
        checks++;
        if (PC !== 9'h056 || redirect_pending !== 1'b0) begin
            failures++;
            $display("FAIL plain_stall pc=%h p=%b exp pc=056 p=0", PC, redirect_pending);
        end
    endtask

    task automatic test_wrap();
        go_to(9'h1FF);
        step();
        checks++;
        if (PC !== 9'h000) begin
            failures++;
            $display("FAIL wrap_zero got=%h exp=000", PC);
        end
        step();
        checks++;
        if (PC !== 9'h001) begin
            failures++;
            $display("FAIL wrap_one got=%h exp=001", PC);
        end
    endtask

    task automatic test_halt();
        go_to(9'h020);
        halt_req = 1'b1;
        step();
        checks++;
        if (state !== 2'b10 || pc_valid !== 1'b0 || PC !== 9'h020 || Flush1 !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter st=%b v=%b pc=%h f=%b exp st=10 v=0 pc=020 f=0",
                     state, pc_valid, PC, Flush1);
        end
        // HALTED ignores branches, stalls and halts.
        br_take = 1'b1; br_target = 9'h133; Stall1 = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (state !== 2'b10 || PC !== 9'h020 || Flush1 !== 1'b0 || redirect_pending !== 1'b0) begin
            failures++;
            $display("FAIL halt_ignore st=%b pc=%h f=%b p=%b exp st=10 pc=020 f=0 p=0",
                     state, PC, Flush1, redirect_pending);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (state !== 2'b01 || PC !== 9'h021 || pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL halt_restart st=%b pc=%h v=%b exp st=01 pc=021 v=1", state, PC, pc_valid);
        end
        // Redirect in the same cycle as halt wins.
        halt_req = 1'b1; br_take = 1'b1; br_target = 9'h100;
        step();
        idle_inputs();
        checks++;
        if (state !== 2'b01 || PC !== 9'h100 || Flush1 !== 1'b1) begin
            failures++;
            $display("FAIL halt_vs_branch st=%b pc=%h f=%b exp st=01 pc=100 f=1", state, PC, Flush1);
        end
    endtask

    task automatic test_reset_mid();
        Stall1 = 1'b1; br_take = 1'b1; br_target = 9'h0AA;
        step();
        br_take = 1'b0;
        checks++;
        if (redirect_pending !== 1'b1) begin
            failures++;
            $display("FAIL mid_pending got=%b exp=1", redirect_pending);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (PC !== 9'h000 || redirect_pending !== 1'b0 || state !== 2'b00 || pc_valid !== 1'b0 || Flush1 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset pc=%h p=%b st=%b v=%b f=%b exp pc=000 p=0 st=00 v=0 f=0",
                     PC, redirect_pending, state, pc_valid, Flush1);
        end
        idle_inputs();
        step();
        reset = 1'b0;
        // Held target was cleared: restart fetch from the reset vector.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (PC !== 9'h001 || Flush1 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset pc=%h f=%b exp pc=001 f=0", PC, Flush1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_start_count();
        test_branch();
        test_stall_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
